// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm ring controller: FSM states, key bus bit
// positions and the seconds-counter type.
package alarm_pkg;

   typedef enum logic [1:0] {
      S_A_IDLE    = 2'd0,
      S_A_RINGING = 2'd1,
      S_A_SNOOZE  = 2'd2
   } alarm_state_e;

   // Bit positions on the debounced key bus
   localparam int unsigned K_SNOOZE = 0;
   localparam int unsigned K_STOP   = 1;
   localparam int unsigned KEY_W    = 2;

   // Wide enough for both the ring and the snooze durations
   localparam int unsigned SEC_W = 9;
   typedef logic [SEC_W-1:0] secs_t;

   function automatic logic last_sec(input secs_t s);
      return s == secs_t'(1);
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Restartable one-second pulse generator: counts 0..TICK_MAX-1 while run is
// high and pulses tick on the last count.
module sec_tick_gen #(
   parameter logic [25:0] TICK_MAX = 26'd50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   logic [25:0] cnt_q, cnt_d;
   logic        at_max;

   assign at_max = (cnt_q == TICK_MAX - 26'd1);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || !run) begin
         cnt_d = '0;
      end else if (at_max) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 26'd1;
      end
   end

   // tick deliberately ignores clr so it never depends on the FSM next state
   assign tick = run && at_max;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: rings with a gated beep pattern, times out automatically,
// and handles a bounded number of snoozes plus stop / disarm.
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter logic [25:0] TICK_MAX    = 26'd50_000_000,
   parameter logic [24:0] BEEP_HALF   = 25'd12_500_000,
   parameter logic [6:0]  RING_SECS   = 7'd60,
   parameter logic [8:0]  SNOOZE_SECS = 9'd300,
   parameter logic [1:0]  MAX_SNOOZE  = 2'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reach_alarm_time,
   input  logic       alarm_en,
   input  logic       key_snooze,
   input  logic       key_stop,
   output logic       buzzer,
   output logic       alarming,
   output logic       snoozing,
   output logic [1:0] snooze_cnt,
   output logic       ring_done
);

   alarm_state_e      state_q, state_d;
   secs_t             sec_left_q, sec_left_d;
   logic [1:0]        snooze_cnt_q, snooze_cnt_d;
   logic [24:0]       beep_cnt_q, beep_cnt_d;
   logic              buzzer_q, buzzer_d;
   logic              ring_done_q, ring_done_d;
   logic [KEY_W-1:0]  keys;
   logic              stop_req;
   logic              tick;
   logic              state_chg;

   assign keys[K_SNOOZE] = key_snooze;
   assign keys[K_STOP]   = key_stop;
   assign stop_req       = keys[K_STOP] || !alarm_en;
   assign state_chg      = (state_d != state_q);

   sec_tick_gen #(
      .TICK_MAX(TICK_MAX)
   ) u_sec_tick_gen (
      .clk (clk),
      .rst (rst),
      .clr (state_chg),
      .run (state_q != S_A_IDLE),
      .tick(tick)
   );

   always_comb begin
      state_d      = state_q;
      sec_left_d   = sec_left_q;
      snooze_cnt_d = snooze_cnt_q;
      unique case (state_q)
         S_A_IDLE: begin
            if (reach_alarm_time && alarm_en) begin
               state_d      = S_A_RINGING;
               sec_left_d   = secs_t'(RING_SECS);
               snooze_cnt_d = 2'd0;
            end
         end
         S_A_RINGING: begin
            if (stop_req) begin
               state_d      = S_A_IDLE;
               snooze_cnt_d = 2'd0;
            end else if (keys[K_SNOOZE] && (snooze_cnt_q < MAX_SNOOZE)) begin
               state_d      = S_A_SNOOZE;
               snooze_cnt_d = snooze_cnt_q + 2'd1;
               sec_left_d   = secs_t'(SNOOZE_SECS);
            end else if (tick) begin
               if (last_sec(sec_left_q)) begin
                  state_d      = S_A_IDLE;
                  snooze_cnt_d = 2'd0;
               end else begin
                  sec_left_d = sec_left_q - secs_t'(1);
               end
            end
         end
         S_A_SNOOZE: begin
            if (stop_req) begin
               state_d      = S_A_IDLE;
               snooze_cnt_d = 2'd0;
            end else if (tick) begin
               if (last_sec(sec_left_q)) begin
                  state_d    = S_A_RINGING;
                  sec_left_d = secs_t'(RING_SECS);
               end else begin
                  sec_left_d = sec_left_q - secs_t'(1);
               end
            end
         end
         default: begin
            state_d      = S_A_IDLE;
            snooze_cnt_d = 2'd0;
         end
      endcase
   end

   // Buzzer starts high on the first RINGING cycle and is low everywhere else
   always_comb begin
      beep_cnt_d = '0;
      buzzer_d   = 1'b0;
      if (state_d == S_A_RINGING) begin
         if (state_q != S_A_RINGING) begin
            buzzer_d = 1'b1;
         end else if (beep_cnt_q == BEEP_HALF - 25'd1) begin
            buzzer_d = ~buzzer_q;
         end else begin
            beep_cnt_d = beep_cnt_q + 25'd1;
            buzzer_d   = buzzer_q;
         end
      end
   end

   assign ring_done_d = (state_q != S_A_IDLE) && (state_d == S_A_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_A_IDLE;
         sec_left_q   <= '0;
         snooze_cnt_q <= 2'd0;
         beep_cnt_q   <= '0;
         buzzer_q     <= 1'b0;
         ring_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sec_left_q   <= sec_left_d;
         snooze_cnt_q <= snooze_cnt_d;
         beep_cnt_q   <= beep_cnt_d;
         buzzer_q     <= buzzer_d;
         ring_done_q  <= ring_done_d;
      end
   end

   assign buzzer     = buzzer_q;
   assign alarming   = (state_q == S_A_RINGING);
   assign snoozing   = (state_q == S_A_SNOOZE);
   assign snooze_cnt = snooze_cnt_q;
   assign ring_done  = ring_done_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with shortened timing parameters.
module tb_alarm_ring_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       reach_alarm_time = 1'b0;
   logic       alarm_en = 1'b0;
   logic       key_snooze = 1'b0;
   logic       key_stop = 1'b0;
   logic       buzzer;
   logic       alarming;
   logic       snoozing;
   logic [1:0] snooze_cnt;
   logic       ring_done;

   int n_checks = 0;
   int n_fail   = 0;

   alarm_ring_ctrl #(
      .TICK_MAX   (26'd10),
      .BEEP_HALF  (25'd3),
      .RING_SECS  (7'd4),
      .SNOOZE_SECS(9'd2),
      .MAX_SNOOZE (2'd2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .reach_alarm_time(reach_alarm_time),
      .alarm_en        (alarm_en),
      .key_snooze      (key_snooze),
      .key_stop        (key_stop),
      .buzzer          (buzzer),
      .alarming        (alarming),
      .snoozing        (snoozing),
      .snooze_cnt      (snooze_cnt),
      .ring_done       (ring_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Pulse reach_alarm_time in cycle 0; returns in cycle 1
   task automatic start_alarm();
      reach_alarm_time = 1'b1;
      cycle();
      reach_alarm_time = 1'b0;
   endtask

   task automatic pulse_keys(input logic snz, input logic stp);
      key_snooze = snz;
      key_stop   = stp;
      cycle();
      key_snooze = 1'b0;
      key_stop   = 1'b0;
   endtask

   initial begin
      // Reset state
      run_cycles(2);
      rst = 1'b0;
      cycle();
      check_eq("rst_alarming", alarming, 0);
      check_eq("rst_snoozing", snoozing, 0);
      check_eq("rst_buzzer", buzzer, 0);
      check_eq("rst_snooze_cnt", snooze_cnt, 0);
      check_eq("rst_ring_done", ring_done, 0);

      // 1: full ring to timeout, beep pattern 3 on / 3 off
      alarm_en = 1'b1;
      start_alarm();
      for (int c = 1; c <= 40; c++) begin
         check_eq("t1_alarming", alarming, 1);
         check_eq("t1_buzzer", buzzer, (((c - 1) / 3) % 2) == 0);
         check_eq("t1_ring_done", ring_done, 0);
         cycle();
      end
      check_eq("t1_timeout_alarming", alarming, 0);
      check_eq("t1_timeout_ring_done", ring_done, 1);
      check_eq("t1_timeout_buzzer", buzzer, 0);
      cycle();
      check_eq("t1_ring_done_pulse", ring_done, 0);

      // 2: snooze at cycle 5, ring resumes at cycle 26
      start_alarm();
      run_cycles(4);
      pulse_keys(1'b1, 1'b0);
      check_eq("t2_snoozing", snoozing, 1);
      check_eq("t2_alarming", alarming, 0);
      check_eq("t2_buzzer", buzzer, 0);
      check_eq("t2_snooze_cnt", snooze_cnt, 1);
      run_cycles(19);
      check_eq("t2_still_snoozing", snoozing, 1);
      cycle();
      check_eq("t2_resume_alarming", alarming, 1);
      check_eq("t2_resume_buzzer", buzzer, 1);
      check_eq("t2_resume_cnt", snooze_cnt, 1);
      pulse_keys(1'b0, 1'b1);
      check_eq("t2_stop_ring_done", ring_done, 1);
      check_eq("t2_stop_cnt", snooze_cnt, 0);

      // 3: snooze limit reached, further snooze ignored, then stop
      cycle();
      start_alarm();
      pulse_keys(1'b1, 1'b0);
      check_eq("t3_snooze1_cnt", snooze_cnt, 1);
      run_cycles(20);
      check_eq("t3_ring2", alarming, 1);
      pulse_keys(1'b1, 1'b0);
      check_eq("t3_snooze2_cnt", snooze_cnt, 2);
      check_eq("t3_snooze2", snoozing, 1);
      run_cycles(20);
      check_eq("t3_ring3", alarming, 1);
      pulse_keys(1'b1, 1'b0);
      check_eq("t3_ignored_alarming", alarming, 1);
      check_eq("t3_ignored_snoozing", snoozing, 0);
      check_eq("t3_ignored_cnt", snooze_cnt, 2);
      pulse_keys(1'b0, 1'b1);
      check_eq("t3_stop_alarming", alarming, 0);
      check_eq("t3_stop_ring_done", ring_done, 1);
      check_eq("t3_stop_cnt", snooze_cnt, 0);

      // 4: stop and snooze together, stop wins
      cycle();
      start_alarm();
      pulse_keys(1'b1, 1'b0);
      run_cycles(20);
      check_eq("t4_ringing", alarming, 1);
      pulse_keys(1'b1, 1'b1);
      check_eq("t4_alarming", alarming, 0);
      check_eq("t4_snoozing", snoozing, 0);
      check_eq("t4_ring_done", ring_done, 1);
      check_eq("t4_cnt", snooze_cnt, 0);

      // 5: disarmed trigger ignored; disarm during snooze ends the event
      cycle();
      alarm_en = 1'b0;
      start_alarm();
      check_eq("t5_disarmed_alarming", alarming, 0);
      check_eq("t5_disarmed_ring_done", ring_done, 0);
      alarm_en = 1'b1;
      start_alarm();
      pulse_keys(1'b1, 1'b0);
      run_cycles(3);
      check_eq("t5_snoozing", snoozing, 1);
      alarm_en = 1'b0;
      cycle();
      alarm_en = 1'b1;
      check_eq("t5_disarm_snoozing", snoozing, 0);
      check_eq("t5_disarm_ring_done", ring_done, 1);
      check_eq("t5_disarm_cnt", snooze_cnt, 0);
      cycle();
      check_eq("t5_ring_done_pulse", ring_done, 0);

      // 6a: asynchronous reset mid-ring
      start_alarm();
      pulse_keys(1'b1, 1'b0);
      run_cycles(20);
      check_eq("t6_pre_alarming", alarming, 1);
      check_eq("t6_pre_cnt", snooze_cnt, 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_async_buzzer", buzzer, 0);
      check_eq("t6_async_alarming", alarming, 0);
      check_eq("t6_async_cnt", snooze_cnt, 0);
      check_eq("t6_async_ring_done", ring_done, 0);
      cycle();
      rst = 1'b0;
      cycle();
      check_eq("t6_post_ring_done", ring_done, 0);
      check_eq("t6_post_alarming", alarming, 0);

      // 6b: retrigger while ringing does not extend the timeout
      start_alarm();
      run_cycles(14);
      start_alarm();
      run_cycles(24);
      check_eq("t6_retrig_alarming", alarming, 1);
      cycle();
      check_eq("t6_retrig_timeout", alarming, 0);
      check_eq("t6_retrig_ring_done", ring_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
